// File: rtl/triad_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// triad_stream_arbiter_if
//  Bundles the triad-side and transmitter-side signals of the triad stream
//  arbiter.
//  master modport: the arbiter.
//  slave modport:  the triads and the serial transmitter.
//  Signals:
//   data_avl           per-triad payload-ready level (triad -> arbiter)
//   sensor_iterations  packed payloads, triad k at [k*PAYLOAD_W +: PAYLOAD_W]
//   reset_parser       one-cycle release pulse per triad (arbiter -> triad)
//   tx_valid           payload offered to the transmitter
//   tx_payload         latched payload of the granted triad
//   tx_channel         index of the granted triad
//   tx_done            one-cycle pulse, transmitter finished the frame
// ---------------------------------------------------------------------------
interface triad_stream_arbiter_if #(
  parameter int N_TRIADS  = 4,
  parameter int PAYLOAD_W = 102
);
  localparam int CH_W = (N_TRIADS > 1) ? $clog2(N_TRIADS) : 1;

  logic [N_TRIADS-1:0]           data_avl;
  logic [N_TRIADS*PAYLOAD_W-1:0] sensor_iterations;
  logic [N_TRIADS-1:0]           reset_parser;
  logic                          tx_valid;
  logic [PAYLOAD_W-1:0]          tx_payload;
  logic [CH_W-1:0]               tx_channel;
  logic                          tx_done;

  modport master (
    input  data_avl, sensor_iterations, tx_done,
    output reset_parser, tx_valid, tx_payload, tx_channel
  );

  modport slave (
    output data_avl, sensor_iterations, tx_done,
    input  reset_parser, tx_valid, tx_payload, tx_channel
  );
endinterface

// File: rtl/triad_stream_arbiter.sv
// ---------------------------------------------------------------------------
// triad_stream_arbiter
//  Owns the free-running system timestamp and arbitrates round-robin between
//  N_TRIADS triad managers that share one serial transmitter. The granted
//  triad's payload is latched and offered with its index; the handshake is
//  guarded by a watchdog, and once the frame ends the triad gets a one-cycle
//  reset_parser pulse.
//  Ports:
//   clk_96MHz      system clock
//   rst_n          asynchronous reset, active low
//   bus            triad/transmitter interface (master side)
//   sys_ts         free-running timestamp, wraps at all-ones
//   timeout_count  saturating count of frames ended by the watchdog
//   busy           high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module triad_stream_arbiter #(
  parameter int N_TRIADS       = 4,
  parameter int PAYLOAD_W      = 102,
  parameter int TS_W           = 24,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk_96MHz,
  input  logic                   rst_n,
  triad_stream_arbiter_if.master bus,
  output logic [TS_W-1:0]        sys_ts,
  output logic [7:0]             timeout_count,
  output logic                   busy
);
  localparam int CH_W = (N_TRIADS > 1) ? $clog2(N_TRIADS) : 1;
  // One spare bit so TIMEOUT_CYCLES-1 always fits, even for powers of two.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_TRIADS - 1);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE, HOLDOFF} state_t;

  state_t          state;
  logic [CH_W-1:0] rr_ptr;
  logic [WD_W-1:0] watchdog;

  logic [PAYLOAD_W-1:0] payload_arr [N_TRIADS];

  generate
    for (genvar gi = 0; gi < N_TRIADS; gi++) begin : g_unpack
      assign payload_arr[gi] = bus.sensor_iterations[gi*PAYLOAD_W +: PAYLOAD_W];
    end
  endgenerate

  // Round-robin pick: scan offsets from the highest down so the smallest
  // offset from rr_ptr overwrites any earlier candidate. The wrap is done by
  // subtraction so non-power-of-two channel counts wrap at N_TRIADS-1.
  logic            grant_any;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] scan_idx;
  int              scan_sum;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int i = N_TRIADS - 1; i >= 0; i--) begin
      scan_sum = int'(rr_ptr) + i;
      if (scan_sum >= N_TRIADS) begin
        scan_sum = scan_sum - N_TRIADS;
      end
      scan_idx = CH_W'(scan_sum);
      if (bus.data_avl[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      sys_ts <= '0;
    end else begin
      sys_ts <= sys_ts + 1'b1;
    end
  end

  always_ff @(posedge clk_96MHz or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      watchdog         <= '0;
      timeout_count    <= '0;
      busy             <= 1'b0;
      bus.tx_valid     <= 1'b0;
      bus.tx_payload   <= '0;
      bus.tx_channel   <= '0;
      bus.reset_parser <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state          <= SEND;
            busy           <= 1'b1;
            bus.tx_valid   <= 1'b1;
            bus.tx_payload <= payload_arr[grant_idx];
            bus.tx_channel <= grant_idx;
            watchdog       <= '0;
          end
        end
        SEND: begin
          // tx_done on the final watchdog cycle still counts as a normal finish.
          if (bus.tx_done || (watchdog == WD_LAST)) begin
            if (!bus.tx_done && (timeout_count != 8'hFF)) begin
              timeout_count <= timeout_count + 8'd1;
            end
            state            <= RELEASE;
            bus.tx_valid     <= 1'b0;
            bus.reset_parser <= N_TRIADS'(1) << bus.tx_channel;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        RELEASE: begin
          state            <= HOLDOFF;
          bus.reset_parser <= '0;
          rr_ptr           <= (bus.tx_channel == CH_LAST) ? '0 : bus.tx_channel + 1'b1;
        end
        HOLDOFF: begin
          // Gives the released triad a cycle to drop data_avl before rescanning.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
